mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 85 ++++++++
 tb/tb_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory port between the fetch and data stages.
// Alternates on contention, times out stuck accesses and pulses a registered ready per access.
module mem_arbiter #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_f,
    output logic        stall_m,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
    state_t     state;
    logic [3:0] wait_cnt;
    logic       prev_d;
    logic       timeout;
    logic       grant_d;

    assign timeout = wait_cnt == 4'(MAX_WAIT - 1);
    // data wins a tie unless it also won the previous grant
    assign grant_d = dm_req & (~if_req | ~prev_d);
    assign stall_f = if_req & ~if_ready;
    assign stall_m = dm_req & ~dm_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            bus_err   <= 1'b0;
            wait_cnt  <= '0;
            prev_d    <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: if (if_req || dm_req) begin
                    state     <= grant_d ? BUSY_D : BUSY_I;
                    mem_en    <= 1'b1;
                    mem_we    <= grant_d & dm_we;
                    mem_addr  <= grant_d ? dm_addr : if_addr;
                    mem_wdata <= grant_d ? dm_wdata : '0;
                    wait_cnt  <= '0;
                    prev_d    <= grant_d;
                end
                BUSY_I, BUSY_D: if (mem_ack || timeout) begin
                    state    <= RESP;
                    mem_en   <= 1'b0;
                    mem_we   <= 1'b0;
                    bus_err  <= ~mem_ack;
                    if_ready <= state == BUSY_I;
                    dm_ready <= state == BUSY_D;
                    if (mem_ack && state == BUSY_I) if_rdata <= mem_rdata;
                    if (mem_ack && state == BUSY_D && !mem_we) dm_rdata <= mem_rdata;
                end else begin
                    wait_cnt <= wait_cnt + 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run against a transaction-timeline model.
module tb_mem_arbiter;
    localparam int MW = 4;
    logic        clk = 1'b0, reset = 1'b0;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ack = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ready, dm_ready, mem_en, mem_we, stall_f, stall_m, bus_err;
    logic [31:0] mem_model [logic [31:0]];
    int          vecs = 0, errs = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_f(stall_f), .stall_m(stall_m), .bus_err(bus_err)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        if_req = 1; dm_req = 1; dm_we = 1; if_addr = 32'h11; dm_addr = 32'h22; dm_wdata = 32'h33;
        mem_ack = 1; mem_rdata = '1;
        repeat (3) @(negedge clk);
        vecs++; if ({mem_en, mem_we, if_ready, dm_ready, bus_err} !== 5'b0) begin
            errs++; $display("FAIL reset_ctrl: got %b want 00000", {mem_en, mem_we, if_ready, dm_ready, bus_err});
        end
        vecs++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errs++; $display("FAIL reset_mem: got addr %h wdata %h want 0 0", mem_addr, mem_wdata);
        end
        vecs++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
            errs++; $display("FAIL reset_rdata: got %h %h want 0 0", if_rdata, dm_rdata);
        end
        vecs++; if ({stall_f, stall_m} !== 2'b11) begin
            errs++; $display("FAIL reset_stall: got %b want 11", {stall_f, stall_m});
        end
        if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
    endtask

    task automatic test_fetch();
        do_reset();
        if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        vecs++; if ({mem_en, mem_we, stall_f} !== 3'b101 || mem_addr !== 32'h100) begin
            errs++; $display("FAIL fetch_busy: got en/we/stall %b addr %h want 101 00000100", {mem_en, mem_we, stall_f}, mem_addr);
        end
        mem_ack = 1; mem_rdata = 32'hE3A00001;
        @(negedge clk);
        mem_ack = 0;
        vecs++; if ({if_ready, stall_f, bus_err, mem_en, dm_ready} !== 5'b10000) begin
            errs++; $display("FAIL fetch_ready: got rdy/stall/err/en/drdy %b want 10000", {if_ready, stall_f, bus_err, mem_en, dm_ready});
        end
        vecs++; if (if_rdata !== 32'hE3A00001) begin
            errs++; $display("FAIL fetch_rdata: got %h want e3a00001", if_rdata);
        end
        if_req = 0;
        @(negedge clk);
        vecs++; if (if_ready !== 1'b0) begin
            errs++; $display("FAIL fetch_pulse: got %b want 0", if_ready);
        end
    endtask

    task automatic test_store();
        dm_req = 1; dm_we = 0; dm_addr = 32'h3000;
        @(negedge clk);
        vecs++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h3000) begin
            errs++; $display("FAIL load_busy: got en %b we %b addr %h want 1 0 00003000", mem_en, mem_we, mem_addr);
        end
        mem_ack = 1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_ack = 0;
        vecs++; if (dm_ready !== 1'b1 || if_ready !== 1'b0 || dm_rdata !== 32'hCAFEF00D) begin
            errs++; $display("FAIL load_ready: got rdy %b irdy %b data %h want 1 0 cafef00d", dm_ready, if_ready, dm_rdata);
        end
        dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'h12345678;
        @(negedge clk);
        vecs++; if (mem_en !== 1'b0) begin
            errs++; $display("FAIL resp_ignores_req: got mem_en %b want 0", mem_en);
        end
        @(negedge clk);
        vecs++; if ({mem_en, mem_we} !== 2'b11 || mem_wdata !== 32'h12345678 || mem_addr !== 32'h2000) begin
            errs++; $display("FAIL store_busy: got en/we %b wdata %h addr %h want 11 12345678 00002000", {mem_en, mem_we}, mem_wdata, mem_addr);
        end
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_ack = 0;
        vecs++; if (dm_ready !== 1'b1 || dm_rdata !== 32'hCAFEF00D) begin
            errs++; $display("FAIL store_ready: got rdy %b data %h want 1 cafef00d", dm_ready, dm_rdata);
        end
        dm_req = 0; dm_we = 0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int busy = 0, k = 0;
        dm_req = 1; dm_we = 0; dm_addr = 32'h4000; mem_ack = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_en) busy++;
            if (dm_ready) break;
        end
        vecs++; if (busy != MW || dm_ready !== 1'b1) begin
            errs++; $display("FAIL timeout_len: got %0d busy rdy %b want %0d 1", busy, dm_ready, MW);
        end
        vecs++; if (bus_err !== 1'b1 || if_ready !== 1'b0) begin
            errs++; $display("FAIL timeout_err: got err %b irdy %b want 1 0", bus_err, if_ready);
        end
        vecs++; if (dm_rdata !== 32'hCAFEF00D) begin
            errs++; $display("FAIL timeout_rdata: got %h want cafef00d", dm_rdata);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dm_ready) break;
            if (mem_en) k++;
            mem_ack = mem_en && k == MW; mem_rdata = 32'h0BADC0DE;
        end
        mem_ack = 0;
        vecs++; if (k != MW || dm_ready !== 1'b1 || bus_err !== 1'b0) begin
            errs++; $display("FAIL late_ack: got busy %0d rdy %b err %b want %0d 1 0", k, dm_ready, bus_err, MW);
        end
        vecs++; if (dm_rdata !== 32'h0BADC0DE) begin
            errs++; $display("FAIL late_ack_rdata: got %h want 0badc0de", dm_rdata);
        end
        dm_req = 0;
        @(negedge clk);
    endtask

    task automatic test_tie();
        logic exp_d = 1'b1, prev_en = 1'b0;
        int   n = 0;
        mem_ack = 0; dm_we = 0; if_addr = 32'h1000; dm_addr = 32'hD000; if_req = 1; dm_req = 1;
        do_reset();
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            vecs++; if (if_ready && dm_ready) begin
                errs++; $display("FAIL tie_ready_excl: got both readies high want at most one");
            end
            if (mem_en && !prev_en) begin
                vecs++; if (mem_addr !== (exp_d ? 32'hD000 : 32'h1000)) begin
                    errs++; $display("FAIL tie_grant%0d: got addr %h want %h", n, mem_addr, exp_d ? 32'hD000 : 32'h1000);
                end
                exp_d = ~exp_d; n++;
            end
            prev_en = mem_en; mem_ack = mem_en;
        end
        vecs++; if (n != 4) begin
            errs++; $display("FAIL tie_grants: got %0d grants want 4", n);
        end
        if_req = 0; dm_req = 0; mem_ack = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        if_req = 1; if_addr = 32'h500;
        repeat (2) @(negedge clk);
        vecs++; if (mem_en !== 1'b1) begin
            errs++; $display("FAIL rst_mid_busy: got mem_en %b want 1", mem_en);
        end
        #1 reset = 1'b0;
        #1;
        vecs++; if (mem_en !== 1'b0) begin
            errs++; $display("FAIL rst_mid_async: got mem_en %b want 0", mem_en);
        end
        dm_req = 1; dm_we = 0; dm_addr = 32'h600;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vecs++; if ({if_ready, dm_ready} !== 2'b00) begin
                errs++; $display("FAIL rst_mid_noready: got %b want 00", {if_ready, dm_ready});
            end
        end
        reset = 1'b1;
        @(negedge clk);
        vecs++; if (mem_en !== 1'b1 || mem_addr !== 32'h600 || if_ready !== 1'b0) begin
            errs++; $display("FAIL rst_mid_regrant: got en %b addr %h irdy %b want 1 00000600 0", mem_en, mem_addr, if_ready);
        end
        mem_ack = 1; mem_rdata = 32'h77;
        @(negedge clk);
        mem_ack = 0;
        vecs++; if (dm_ready !== 1'b1 || if_ready !== 1'b0 || dm_rdata !== 32'h77) begin
            errs++; $display("FAIL rst_mid_done: got drdy %b irdy %b data %h want 1 0 00000077", dm_ready, if_ready, dm_rdata);
        end
        if_req = 0; dm_req = 0;
        @(negedge clk);
    endtask

    // Timeline model: a grant at edge e with ack on busy cycle lat occupies cycles
    // e+1..e+n (n = min(lat, MW)), readies in cycle e+n+1, and frees the port at edge e+n+2.
    task automatic test_random(input int ncyc);
        int          free_at = 0, ge = -10, gn = 0, glat = 0;
        logic        busy_ok = 0, gd = 0, gerr = 0, gwe = 0, last_d = 0, i_act = 0, d_act = 0;
        logic        in_busy, rdy, d;
        logic [31:0] ga = 0, gw = 0, gr = 0, exp_ir = 0, exp_dr = 0;
        if_req = 0; dm_req = 0; mem_ack = 0;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) @(negedge clk);
            in_busy = busy_ok && c > ge && c <= ge + gn;
            rdy = busy_ok && c == ge + gn + 1;
            if (rdy && !gerr) begin
                if (!gd) exp_ir = gr;
                else if (!gwe) exp_dr = gr;
                else mem_model[ga] = gw;
            end
            vecs++; if (mem_en !== in_busy) begin
                errs++; $display("FAIL rnd_mem_en c=%0d: got %b want %b", c, mem_en, in_busy);
            end
            if (in_busy) begin
                vecs++; if (mem_addr !== ga || mem_we !== gwe || (gwe && mem_wdata !== gw)) begin
                    errs++; $display("FAIL rnd_mem_bus c=%0d: got %h/%b/%h want %h/%b/%h", c, mem_addr, mem_we, mem_wdata, ga, gwe, gw);
                end
            end
            vecs++; if ({if_ready, dm_ready, bus_err} !== {rdy && !gd, rdy && gd, rdy && gerr}) begin
                errs++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, {if_ready, dm_ready, bus_err}, {rdy && !gd, rdy && gd, rdy && gerr});
            end
            vecs++; if (if_rdata !== exp_ir || dm_rdata !== exp_dr) begin
                errs++; $display("FAIL rnd_rdata c=%0d: got %h %h want %h %h", c, if_rdata, dm_rdata, exp_ir, exp_dr);
            end
            vecs++; if ({stall_f, stall_m} !== {if_req && !(rdy && !gd), dm_req && !(rdy && gd)}) begin
                errs++; $display("FAIL rnd_stall c=%0d: got %b want %b", c, {stall_f, stall_m}, {if_req && !(rdy && !gd), dm_req && !(rdy && gd)});
            end
            if (rdy && gd) begin d_act = 0; dm_req = 0; end
            if (rdy && !gd) begin i_act = 0; if_req = 0; end
            if (in_busy && $urandom_range(0, 7) == 0) begin
                if (gd) dm_req = 0;
                else if_req = 0;
            end
            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act = 1; if_req = 1; if_addr = 32'h100 + 4 * $urandom_range(0, 7);
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1; dm_req = 1; dm_we = 1'($urandom_range(0, 1));
                dm_addr = 32'h100 + 4 * $urandom_range(0, 7); dm_wdata = $urandom;
            end
            if (in_busy) begin
                mem_ack = (c - ge) == glat;
                mem_rdata = mem_ack ? mem_rd(ga) : $urandom;
                if (mem_ack) gr = mem_rd(ga);
            end else begin
                mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            end
            if (c >= free_at && (if_req || dm_req)) begin
                d = dm_req && (!if_req || !last_d);
                busy_ok = 1; ge = c; gd = d; glat = $urandom_range(1, MW + 2);
                gn = glat > MW ? MW : glat; gerr = glat > MW;
                ga = d ? dm_addr : if_addr; gwe = d && dm_we; gw = dm_wdata;
                last_d = d; free_at = c + gn + 2;
            end
        end
        if_req = 0; dm_req = 0; mem_ack = 0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_timeout();
        test_tie();
        test_reset_mid();
        test_random(3000);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
